// File: rtl/divider_restoring_pkg.sv
// Shared types and helpers for the restoring divider.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    // Width of an iteration counter that must hold the value w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/divider_restoring_if.sv
// START / result handshake bus shared by the divider and its controller.
interface divider_restoring_if #(
    parameter int tamano = 8
);
    logic              START;
    logic [tamano-1:0] A;
    logic [tamano-1:0] B;
    logic [tamano-1:0] Q;
    logic [tamano-1:0] R;
    logic              END_DIV;
    logic              DIV_ZERO;
    logic              BUSY;

    modport master (
        output START, A, B,
        input  Q, R, END_DIV, DIV_ZERO, BUSY
    );

    modport slave (
        input  START, A, B,
        output Q, R, END_DIV, DIV_ZERO, BUSY
    );
endinterface

// File: rtl/divider_restoring_fsm.sv
// Divider controller: state register, iteration counter and datapath strobes.
module divider_fsm
    import divider_pkg::*;
#(
    parameter int tamano = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic b_zero_i,
    output logic load_o,
    output logic load_zero_o,
    output logic shift_o,
    output logic done_o,
    output logic idle_o
);

    localparam int CNT_W = cnt_width(tamano);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and strobe decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_o      = 1'b0;
        load_zero_o = 1'b0;
        shift_o     = 1'b0;
        done_o      = 1'b0;
        idle_o      = 1'b0;
        case (state_q)
            IDLE: begin
                idle_o = 1'b1;
                if (start_i) begin
                    if (b_zero_i) begin
                        load_zero_o = 1'b1;
                        state_d     = DONE;
                    end else begin
                        load_o  = 1'b1;
                        cnt_d   = CNT_W'(tamano);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                shift_o = 1'b1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/divider_restoring.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
module divider_restoring
    import divider_pkg::*;
#(
    parameter int tamano = 8
) (
    input  logic         CLOCK,
    input  logic         RESET,
    divider_restoring_if.slave bus
);

    logic load, load_zero, shift, done, idle;

    divider_fsm #(.tamano(tamano)) u_fsm (
        .clk_i       (CLOCK),
        .rst_i       (RESET),
        .start_i     (bus.START),
        .b_zero_i    (bus.B == '0),
        .load_o      (load),
        .load_zero_o (load_zero),
        .shift_o     (shift),
        .done_o      (done),
        .idle_o      (idle)
    );

    logic [tamano:0]   pr_q, pr_d;
    logic [tamano-1:0] qs_q, qs_d;
    logic [tamano-1:0] ds_q, ds_d;
    logic              dz_q, dz_d;
    logic [tamano-1:0] q_q, q_d;
    logic [tamano-1:0] r_q, r_d;
    logic              end_q, end_d;
    logic              divz_q, divz_d;
    logic              busy_q, busy_d;
    logic [tamano:0]   trial, diff;

    // Datapath and output register next-state; PR is one bit wider so the borrow is explicit.
    always_comb begin
        pr_d   = pr_q;
        qs_d   = qs_q;
        ds_d   = ds_q;
        dz_d   = dz_q;
        q_d    = q_q;
        r_d    = r_q;
        divz_d = divz_q;
        end_d  = done;
        busy_d = !idle || load || load_zero;
        trial  = {pr_q[tamano-1:0], qs_q[tamano-1]};
        diff   = trial - {1'b0, ds_q};
        if (load) begin
            qs_d   = bus.A;
            ds_d   = bus.B;
            pr_d   = '0;
            dz_d   = 1'b0;
            divz_d = 1'b0;
        end
        if (load_zero) begin
            qs_d   = '1;
            ds_d   = bus.B;
            pr_d   = {1'b0, bus.A};
            dz_d   = 1'b1;
            divz_d = 1'b0;
        end
        if (shift) begin
            pr_d = diff[tamano] ? trial : diff;
            qs_d = {qs_q[tamano-2:0], ~diff[tamano]};
        end
        if (done) begin
            q_d    = qs_q;
            r_d    = pr_q[tamano-1:0];
            divz_d = dz_q;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            pr_q   <= '0;
            qs_q   <= '0;
            ds_q   <= '0;
            dz_q   <= 1'b0;
            q_q    <= '0;
            r_q    <= '0;
            end_q  <= 1'b0;
            divz_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            pr_q   <= pr_d;
            qs_q   <= qs_d;
            ds_q   <= ds_d;
            dz_q   <= dz_d;
            q_q    <= q_d;
            r_q    <= r_d;
            end_q  <= end_d;
            divz_q <= divz_d;
            busy_q <= busy_d;
        end
    end

    assign bus.Q        = q_q;
    assign bus.R        = r_q;
    assign bus.END_DIV  = end_q;
    assign bus.DIV_ZERO = divz_q;
    assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_divider_restoring.sv
// Directed and sweep checks for divider_restoring (tamano = 8).
module tb_divider_restoring;

    logic CLOCK = 1'b0;
    logic RESET;

    always #5 CLOCK = ~CLOCK;

    divider_restoring_if #(.tamano(8)) bus ();

    divider_restoring #(.tamano(8)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] q, r, ra, rb;
    logic       dz;
    int         lat, busyn, npulse, p1, p2, seen;

    logic [7:0] va [4] = '{8'd255, 8'd5, 8'd0, 8'd255};
    logic [7:0] vb [4] = '{8'd1,   8'd9, 8'd3, 8'd255};
    logic [7:0] vq [4] = '{8'd255, 8'd0, 8'd0, 8'd1};
    logic [7:0] vr [4] = '{8'd0,   8'd5, 8'd0, 8'd0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one division, scramble operands after capture, wait (bounded) for END_DIV.
    task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] oq, output logic [7:0] orr,
                          output logic odz, output int olat, output int obusy);
        @(negedge CLOCK);
        bus.START = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(posedge CLOCK);
        #1;
        bus.START = 1'b0;
        bus.A     = 8'($urandom);
        bus.B     = 8'($urandom);
        olat  = 99;
        obusy = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLOCK);
            if (bus.BUSY) obusy++;
            if (bus.END_DIV) begin
                olat = n;
                break;
            end
            @(posedge CLOCK);
        end
        oq  = bus.Q;
        orr = bus.R;
        odz = bus.DIV_ZERO;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        RESET     = 1'b1;
        bus.START = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        #12;
        chk("rst_Q", bus.Q, 0);
        chk("rst_R", bus.R, 0);
        chk("rst_END", bus.END_DIV, 0);
        chk("rst_DZ", bus.DIV_ZERO, 0);
        chk("rst_BUSY", bus.BUSY, 0);
        @(negedge CLOCK);
        RESET = 1'b0;

        // 100 / 7
        do_div(8'd100, 8'd7, q, r, dz, lat, busyn);
        chk("d100_7_Q", q, 14);
        chk("d100_7_R", r, 2);
        chk("d100_7_DZ", dz, 0);
        chk("d100_7_lat", lat, 9);
        chk("d100_7_busy", busyn, 10);
        @(negedge CLOCK);
        chk("pulse_end", bus.END_DIV, 0);
        chk("pulse_busy", bus.BUSY, 0);
        chk("hold_Q", bus.Q, 14);

        // Boundary vectors
        for (int i = 0; i < 4; i++) begin
            do_div(va[i], vb[i], q, r, dz, lat, busyn);
            chk("vec_Q", q, vq[i]);
            chk("vec_R", r, vr[i]);
            chk("vec_DZ", dz, 0);
            chk("vec_lat", lat, 9);
        end

        // Divide by zero, then recovery
        do_div(8'd77, 8'd0, q, r, dz, lat, busyn);
        chk("dz_Q", q, 255);
        chk("dz_R", r, 77);
        chk("dz_DZ", dz, 1);
        chk("dz_lat", lat, 1);
        chk("dz_busy", busyn, 2);
        @(negedge CLOCK);
        chk("dz_hold", bus.DIV_ZERO, 1);
        chk("dz_end_low", bus.END_DIV, 0);
        do_div(8'd9, 8'd3, q, r, dz, lat, busyn);
        chk("after_dz_Q", q, 3);
        chk("after_dz_R", r, 0);
        chk("after_dz_DZ", dz, 0);

        // START held high, operands disturbed mid-CALC
        @(negedge CLOCK);
        bus.START = 1'b1;
        bus.A     = 8'd200;
        bus.B     = 8'd13;
        npulse = 0;
        p1 = -1;
        p2 = -1;
        for (int c = 0; c < 25; c++) begin
            @(posedge CLOCK);
            #1;
            if ((c % 10) >= 2 && (c % 10) <= 6) begin
                bus.A = 8'd1;
                bus.B = 8'd1;
            end else begin
                bus.A = 8'd200;
                bus.B = 8'd13;
            end
            @(negedge CLOCK);
            if (bus.END_DIV) begin
                npulse++;
                if (p1 < 0) p1 = c;
                else if (p2 < 0) p2 = c;
                chk("held_Q", bus.Q, 15);
                chk("held_R", bus.R, 5);
            end
        end
        chk("held_pulses", npulse, 2);
        chk("held_first", p1, 9);
        chk("held_spacing", p2 - p1, 10);
        bus.START = 1'b0;
        repeat (15) @(negedge CLOCK);

        // Reset in the middle of CALC
        @(negedge CLOCK);
        bus.START = 1'b1;
        bus.A     = 8'd100;
        bus.B     = 8'd7;
        @(posedge CLOCK);
        #1;
        bus.START = 1'b0;
        repeat (4) @(posedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b1;
        #1;
        chk("mid_rst_Q", bus.Q, 0);
        chk("mid_rst_R", bus.R, 0);
        chk("mid_rst_BUSY", bus.BUSY, 0);
        chk("mid_rst_END", bus.END_DIV, 0);
        chk("mid_rst_DZ", bus.DIV_ZERO, 0);
        @(negedge CLOCK);
        RESET = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge CLOCK);
            if (bus.END_DIV) seen = 1;
        end
        chk("mid_rst_no_end", seen, 0);
        do_div(8'd100, 8'd7, q, r, dz, lat, busyn);
        chk("post_rst_Q", q, 14);
        chk("post_rst_R", r, 2);
        chk("post_rst_lat", lat, 9);

        // Random sweep against the division identity
        for (int k = 0; k < 2000; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom_range(255, 1));
            do_div(ra, rb, q, r, dz, lat, busyn);
            chk("rnd_identity", 32'(q) * 32'(rb) + 32'(r), 32'(ra));
            chk("rnd_r_lt_b", 32'(r < rb), 1);
            chk("rnd_lat", lat, 9);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/divider_restoring.md
Name: divider_restoring

Overview:
Sequential unsigned restoring (shift-and-subtract) divider. It is the inverse-operation companion to the shift-and-add multiplier in the arithmetic datapath.
- Computes one quotient bit per clock.
- Uses the same START / end-of-operation handshake as the multiplier, so one controller can sequence both units.
- Its results feed the same result bus consumers as the multiplier product S.

Parameters:
tamano, 8, operand width in bits (dividend, divisor, quotient, remainder); minimum 2.

Ports:
CLOCK  input  1  system clock, all state updates on rising edge
RESET  input  1  asynchronous, active-high reset
START  input  1  request a division; sampled only in IDLE
A  input  tamano  dividend, unsigned, captured on accepted START
B  input  tamano  divisor, unsigned, captured on accepted START
Q  output  tamano  quotient, valid from END_DIV until the next accepted START
R  output  tamano  remainder, valid from END_DIV until the next accepted START
END_DIV  output  1  one-cycle pulse marking result valid
DIV_ZERO  output  1  set with END_DIV when B was 0; held until the next accepted START
BUSY  output  1  high from the accepted START through the DONE cycle

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - state = IDLE; Q, R = 0; END_DIV, DIV_ZERO, BUSY = 0; internal registers and counter = 0.
  - An in-flight division is discarded with no END_DIV.
- States: IDLE, CALC, DONE.
- IDLE:
  - START=1 and B!=0 -> capture A into the quotient shift register QS, B into DS; clear the partial remainder PR (tamano+1 bits); cnt = tamano; clear DIV_ZERO; go to CALC.
  - START=1 and B=0 -> QS = all ones, PR = A, DIV_ZERO = 1; go to DONE (no CALC cycles).
  - START=0 -> stay; Q and R hold their last results.
- CALC, one iteration per cycle:
  - t = {PR[tamano-1:0], QS[tamano-1]}, width tamano+1.
  - d = t - {1'b0, DS}.
  - If d[tamano] = 1 (negative): restore, PR = t, QS = {QS[tamano-2:0], 0}.
  - Otherwise: PR = d, QS = {QS[tamano-2:0], 1}.
  - cnt decrements each iteration; after the iteration where cnt = 1, go to DONE.
- DONE, exactly one cycle:
  - Q = QS; R = PR[tamano-1:0]; END_DIV = 1; BUSY = 1.
  - Next state IDLE unconditionally.
- Outputs are registered. Q and R change only on entry to DONE (or on reset).
- Latency:
  - START sampled at edge 0 -> END_DIV high in the cycle after edge tamano+1 (10 cycles for tamano = 8).
  - Divide-by-zero: END_DIV high after edge 1.
- START while BUSY (CALC or DONE) is ignored: operands are not recaptured and no queueing occurs.
- A and B may change freely after the capturing edge.
- Back-to-back: a START asserted in the cycle after DONE (state IDLE) is accepted. Throughput is one division per tamano+2 cycles.
- Width rule: PR is tamano+1 bits so the subtract borrow is explicit. Remainder is always < B when B != 0.
- Invariant checked by the bench: A == Q*B + R when DIV_ZERO = 0.

Decomposition:
- Shared package divider_pkg:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t.
  - Function clog2-based counter width CNT_W = $clog2(tamano+1).
- One sub-module: divider_fsm (state register, counter, load/shift/done strobes). The top holds the PR/QS/DS datapath and output registers, mirroring the controller/datapath split of the multiplier.

Test Plan:
- tamano=8: A=100, B=7, START one cycle -> after 10 cycles END_DIV pulse, Q=14, R=2, DIV_ZERO=0; BUSY high for 10 cycles.
- A=255, B=1 -> Q=255, R=0. A=5, B=9 -> Q=0, R=5. A=0, B=3 -> Q=0, R=0. A=255, B=255 -> Q=1, R=0.
- A=77, B=0 -> END_DIV 2 cycles after START, Q=255, R=77, DIV_ZERO=1. The next START with A=9, B=3 gives DIV_ZERO=0, Q=3, R=0.
- START=1 held continuously with A=200, B=13 -> consecutive results Q=15, R=5, END_DIV pulses exactly 10 cycles apart. Changing A/B during CALC does not alter the result.
- RESET pulsed mid-CALC (cycle 4) -> all outputs 0 immediately and no END_DIV. A fresh START then completes normally.
- Random sweep: 2000 operand pairs -> A == Q*B + R and R < B for every B != 0.
